// File: rtl/multicycle_cpu_if.sv
// Instruction-memory bus between the CPU (master) and the program store (slave).
// Data is expected one cycle after the address is presented.
interface multicycle_cpu_if #(
    parameter int PC_W = 7
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/multicycle_cpu.sv
// Four-state multicycle CPU: FETCH -> DECODE -> EXEC -> WB, with a sticky HALT.
// Register file, PC, status outputs and instruction register share one reset domain.
module multicycle_cpu #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 7,
    parameter int NREGS  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    multicycle_cpu_if.master    imem,
    output logic [DATA_W-1:0]   out,
    output logic [PC_W-1:0]     pc_out,
    output logic                zero,
    output logic                halted,
    output logic                wb_en
);
    localparam int RIDX_W = $clog2(NREGS);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t              state_reg;
    logic [PC_W-1:0]     pc_reg;
    logic [31:0]         ir_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   alu_reg;
    logic [DATA_W-1:0]   rf [NREGS];

    logic [3:0]          ir_op;
    logic [RIDX_W-1:0]   ir_rd;
    logic [15:0]         ir_imm;
    logic [RIDX_W-1:0]   dec_rs1;
    logic [RIDX_W-1:0]   dec_rs2;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   alu_next;
    logic                is_alu;
    logic                unused_ir;

    assign ir_op   = ir_reg[31:28];
    assign ir_rd   = ir_reg[24 +: RIDX_W];
    assign ir_imm  = ir_reg[15:0];
    // Operands are read in DECODE, before the instruction register has captured the word.
    assign dec_rs1 = imem.imem_data[20 +: RIDX_W];
    assign dec_rs2 = imem.imem_data[16 +: RIDX_W];
    // Source fields and high index bits are consumed only at decode time.
    assign unused_ir = ^ir_reg;

    generate
        if (DATA_W > 16) begin : g_imm_sext
            assign imm_ext = {{(DATA_W-16){ir_imm[15]}}, ir_imm};
        end else begin : g_imm_trunc
            assign imm_ext = ir_imm[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        alu_next = '0;
        is_alu   = 1'b1;
        case (ir_op)
            OP_ADD:  alu_next = a_reg + b_reg;
            OP_SUB:  alu_next = a_reg - b_reg;
            OP_AND:  alu_next = a_reg & b_reg;
            OP_OR:   alu_next = a_reg | b_reg;
            OP_ADDI: alu_next = a_reg + imm_ext;
            default: is_alu   = 1'b0;
        endcase
    end

    assign imem.imem_addr = pc_reg;
    assign pc_out         = pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_reg   <= '0;
            out       <= '0;
            zero      <= 1'b0;
            halted    <= 1'b0;
            wb_en     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            wb_en <= 1'b0;
            case (state_reg)
                FETCH: begin
                    if (run) begin
                        state_reg <= DECODE;
                    end
                end
                DECODE: begin
                    ir_reg    <= imem.imem_data;
                    a_reg     <= rf[dec_rs1];
                    b_reg     <= rf[dec_rs2];
                    state_reg <= EXEC;
                end
                EXEC: begin
                    if (is_alu) begin
                        alu_reg <= alu_next;
                        zero    <= (alu_next == '0);
                    end
                    state_reg <= WB;
                end
                WB: begin
                    // r0 is never written, so it keeps reading as zero.
                    if (is_alu && (ir_rd != '0)) begin
                        rf[ir_rd] <= alu_reg;
                        out       <= alu_reg;
                        wb_en     <= 1'b1;
                    end
                    state_reg <= FETCH;
                    case (ir_op)
                        OP_BEQ: begin
                            if (a_reg == b_reg) begin
                                pc_reg <= pc_reg + ir_imm[PC_W-1:0];
                            end else begin
                                pc_reg <= pc_reg + PC_W'(1);
                            end
                        end
                        OP_JMP:  pc_reg <= ir_imm[PC_W-1:0];
                        OP_HALT: begin
                            state_reg <= HALT;
                            halted    <= 1'b1;
                        end
                        default: pc_reg <= pc_reg + PC_W'(1);
                    endcase
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set datapath, register and result width.
REQ-002 Parameter PC_W, default 7, SHALL set program-counter and instruction-address width.
REQ-003 Parameter NREGS, default 8, power of two, 2..16, SHALL set register-file depth.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 run  input  1  SHALL allow a new fetch when high and SHALL be sampled only in FETCH.
REQ-007 imem_addr  output  PC_W  SHALL be the instruction address, equal to the PC.
REQ-008 imem_data  input  32  SHALL be the instruction word, valid one cycle after imem_addr is presented.
REQ-009 out  output  DATA_W  SHALL hold the last value written to the register file.
REQ-010 pc_out  output  PC_W  SHALL equal the current PC.
REQ-011 zero  output  1  SHALL be high when the last ALU result was 0.
REQ-012 halted  output  1  SHALL be high while in HALT.
REQ-013 wb_en  output  1  SHALL pulse for exactly one cycle per register write.

Function
REQ-014 Instruction fields SHALL be: op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0]; register indices SHALL use their low log2(NREGS) bits.
REQ-015 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI (rs1+imm), 6 BEQ, 7 JMP, 15 HALT; undefined opcodes SHALL execute as NOP.
REQ-016 imm SHALL be sign-extended or truncated to DATA_W; all arithmetic SHALL be modulo 2^DATA_W with carry discarded.
REQ-017 Register 0 SHALL read as 0, and writes to it SHALL be discarded, with no wb_en pulse.
REQ-018 The FSM SHALL have states FETCH, DECODE, EXEC, WB and HALT.
REQ-019 FETCH SHALL go to DECODE when run=1 and SHALL stay in FETCH otherwise.
REQ-020 Transitions DECODE->EXEC and EXEC->WB SHALL be unconditional.
REQ-021 WB SHALL go to FETCH, or to HALT for opcode 15.
REQ-022 HALT SHALL be exited only by reset.
REQ-023 The instruction register SHALL latch imem_data in DECODE.
REQ-024 In DECODE, operands SHALL be read from the register file.
REQ-025 EXEC SHALL compute the ALU result and update zero for ADD, SUB, AND, OR and ADDI only.
REQ-026 In WB, the register-file write, out update and wb_en pulse SHALL occur for opcodes 1-5.
REQ-027 Each instruction SHALL take exactly 4 cycles from FETCH entry to the next FETCH entry when run=1.
REQ-028 In WB, the PC SHALL update to pc+1 by default.
REQ-029 For BEQ, the WB PC update SHALL be pc+imm[PC_W-1:0] when rs1==rs2.
REQ-030 For JMP, the WB PC update SHALL be imm[PC_W-1:0].
REQ-031 For HALT, the PC SHALL hold.
REQ-032 All PC arithmetic SHALL wrap modulo 2^PC_W.
REQ-033 A read of the register being written in the same cycle SHALL return the old value; the sequencing makes this unreachable, but it is defined.
REQ-034 Dropping run in a state other than FETCH SHALL NOT stall the current instruction.

Reset
REQ-035 Asserting reset low SHALL immediately force state=FETCH, PC=0, out=0, zero=0, halted=0, wb_en=0, instruction register=0 and all registers=0, regardless of the current state.
REQ-036 Reset SHALL abort any in-flight instruction with no partial register write.
REQ-037 After reset deasserts, the first fetch SHALL occur on the first rising edge with run=1.

Verification
REQ-038 Scenario, ADDI then ADD: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; run=1 -> out=12 and wb_en pulsed 3 times by cycle 12, and pc_out=3.
REQ-039 Scenario, wrap: ADDI r1,r0,0xFFFF; ADDI r1,r1,1 -> out=0 and zero=1.
REQ-040 Scenario, SUB to zero: SUB r4,r1,r1 -> out=0 and zero=1.
REQ-041 Scenario, branch taken: BEQ r0,r0,imm=3 at pc 10 -> PC=13 and no wb_en pulse.
REQ-042 Scenario, PC wrap: JMP 127, then NOP -> pc_out=0.
REQ-043 Scenario, HALT: HALT instruction -> halted=1 and pc_out frozen for 20 cycles.
REQ-044 Scenario, run low: run=0 held in FETCH for 10 cycles -> state and PC unchanged.
REQ-045 Scenario, reset mid-EXEC of ADD r5 -> r5 reads 0 after reset and out=0.
